alu_sched: RTL

Two-requester scheduler and sequencer for the shared 16-bit ALU. Arbitrates round-robin between requesters A and B, latches the granted request, and drives the ALU's `control`/`bgn`/`sh`/`pos`/`nr1`/`nr2` inputs for the correct number of cycles. Waits for `fin` on the iterative ops (divide, multiply) or a fixed settle time on single-pass ops. Returns the 32-bit result and flags on a valid/ready response port. Sits between the register-file/bus front end and the ALU instance.

---
 rtl/alu_sched.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - round-robin two-requester scheduler/sequencer for the shared 16-bit ALU
module alu_sched #(
   parameter int unsigned SETTLE  = 2,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        a_req,
   input  logic [3:0]  a_op,
   input  logic [15:0] a_nr1,
   input  logic [15:0] a_nr2,
   input  logic        a_sh,
   input  logic [3:0]  a_pos,
   output logic        a_gnt,
   input  logic        b_req,
   input  logic [3:0]  b_op,
   input  logic [15:0] b_nr1,
   input  logic [15:0] b_nr2,
   input  logic        b_sh,
   input  logic [3:0]  b_pos,
   output logic        b_gnt,
   output logic [3:0]  alu_control,
   output logic        alu_bgn,
   output logic        alu_sh,
   output logic [3:0]  alu_pos,
   output logic [15:0] alu_nr1,
   output logic [15:0] alu_nr2,
   input  logic [31:0] alu_outbus,
   input  logic        alu_carry_next,
   input  logic        alu_borrow_next,
   input  logic        alu_fin,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_data,
   output logic        rsp_carry,
   output logic        rsp_borrow,
   output logic        rsp_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE - 1);
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q;
   logic        rr_q;
   logic [7:0]  cnt_q;
   logic        fin_q;
   logic        id_q;

   logic [3:0]  alu_control_q;
   logic        alu_bgn_q;
   logic        alu_sh_q;
   logic [3:0]  alu_pos_q;
   logic [15:0] alu_nr1_q;
   logic [15:0] alu_nr2_q;

   logic        rsp_valid_q;
   logic        rsp_id_q;
   logic [31:0] rsp_data_q;
   logic        rsp_carry_q;
   logic        rsp_borrow_q;
   logic        rsp_err_q;

   logic        gnt_a_d;
   logic        gnt_b_d;
   logic [3:0]  sel_op_d;
   logic [15:0] sel_nr1_d;
   logic [15:0] sel_nr2_d;
   logic        sel_sh_d;
   logic [3:0]  sel_pos_d;
   logic        iter_q;

   // Grant only in IDLE; rr_q picks the winner when both ask; gated by rst_n so outputs read 0 in reset
   always_comb begin
      gnt_a_d = 1'b0;
      gnt_b_d = 1'b0;
      if (rst_n && state_q == S_IDLE) begin
         if (a_req && (!b_req || !rr_q)) begin
            gnt_a_d = 1'b1;
         end else if (b_req) begin
            gnt_b_d = 1'b1;
         end
      end
   end

   // Operand mux for whichever side is being granted this cycle
   always_comb begin
      sel_op_d  = gnt_b_d ? b_op  : a_op;
      sel_nr1_d = gnt_b_d ? b_nr1 : a_nr1;
      sel_nr2_d = gnt_b_d ? b_nr2 : a_nr2;
      sel_sh_d  = gnt_b_d ? b_sh  : a_sh;
      sel_pos_d = gnt_b_d ? b_pos : a_pos;
   end

   // Only legal ops reach RUN, so the held control code tells us whether to wait for fin
   assign iter_q = (alu_control_q == 4'd0) || (alu_control_q == 4'd1);

   // Sequencer: grant latch, ALU drive, run timing and response capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         rr_q          <= 1'b0;
         cnt_q         <= 8'd0;
         fin_q         <= 1'b0;
         id_q          <= 1'b0;
         alu_control_q <= 4'd0;
         alu_bgn_q     <= 1'b0;
         alu_sh_q      <= 1'b0;
         alu_pos_q     <= 4'd0;
         alu_nr1_q     <= 16'd0;
         alu_nr2_q     <= 16'd0;
         rsp_valid_q   <= 1'b0;
         rsp_id_q      <= 1'b0;
         rsp_data_q    <= 32'd0;
         rsp_carry_q   <= 1'b0;
         rsp_borrow_q  <= 1'b0;
         rsp_err_q     <= 1'b0;
      end else begin
         alu_bgn_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (gnt_a_d || gnt_b_d) begin
                  id_q <= gnt_b_d;
                  rr_q <= ~gnt_b_d;
                  if (sel_op_d >= 4'd7) begin
                     // Illegal op never touches the ALU; answer with an error at once
                     rsp_valid_q  <= 1'b1;
                     rsp_id_q     <= gnt_b_d;
                     rsp_data_q   <= 32'd0;
                     rsp_carry_q  <= 1'b0;
                     rsp_borrow_q <= 1'b0;
                     rsp_err_q    <= 1'b1;
                     state_q      <= S_DONE;
                  end else begin
                     alu_control_q <= sel_op_d;
                     alu_nr1_q     <= sel_nr1_d;
                     alu_nr2_q     <= sel_nr2_d;
                     alu_sh_q      <= sel_sh_d;
                     alu_pos_q     <= sel_pos_d;
                     alu_bgn_q     <= (sel_op_d == 4'd0) || (sel_op_d == 4'd1);
                     state_q       <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               cnt_q   <= 8'd0;
               fin_q   <= 1'b0;
               state_q <= S_RUN;
            end
            S_RUN: begin
               // fin is registered so iterative results report two edges after fin is seen
               fin_q <= alu_fin;
               if (!iter_q) begin
                  if (cnt_q == SETTLE_LAST) begin
                     state_q <= S_DRAIN;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end else if (fin_q) begin
                  state_q <= S_DRAIN;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  rsp_valid_q  <= 1'b1;
                  rsp_id_q     <= id_q;
                  rsp_data_q   <= 32'd0;
                  rsp_carry_q  <= 1'b0;
                  rsp_borrow_q <= 1'b0;
                  rsp_err_q    <= 1'b1;
                  state_q      <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_DRAIN: begin
               rsp_valid_q  <= 1'b1;
               rsp_id_q     <= id_q;
               rsp_data_q   <= alu_outbus;
               rsp_carry_q  <= alu_carry_next;
               rsp_borrow_q <= alu_borrow_next;
               rsp_err_q    <= 1'b0;
               state_q      <= S_DONE;
            end
            S_DONE: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign a_gnt       = gnt_a_d;
   assign b_gnt       = gnt_b_d;
   assign alu_control = alu_control_q;
   assign alu_bgn     = alu_bgn_q;
   assign alu_sh      = alu_sh_q;
   assign alu_pos     = alu_pos_q;
   assign alu_nr1     = alu_nr1_q;
   assign alu_nr2     = alu_nr2_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_id      = rsp_id_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_carry   = rsp_carry_q;
   assign rsp_borrow  = rsp_borrow_q;
   assign rsp_err     = rsp_err_q;

endmodule
